// File: rtl/fp32_tb_pkg.sv
// Shared types and constants for the fp32 adder stimulus sequencer.
// Holds the FSM state enum, LFSR masks and the directed corner-case operand table.
package fp32_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIRECTED,
        ST_RANDOM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0]  FP32_EXP_MIN = 8'h01;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFE;

    localparam logic [31:0] OPND_MASK    = 32'h8020_0003;
    localparam logic [31:0] X2_SEED_XOR  = 32'h5A5A_5A5A;
    localparam logic [15:0] BUBBLE_MASK  = 16'hB400;
    localparam logic [15:0] BUBBLE_SEED  = 16'hBEEF;

    localparam logic [0:7][31:0] DIR_X1 = {
        32'h3F80_0000, 32'h3F80_0000, 32'h4049_0FDB, 32'h7F7F_FFFF,
        32'h0080_0000, 32'h3F80_0000, 32'h4B7F_FFFF, 32'hC0A0_0000
    };
    localparam logic [0:7][31:0] DIR_X2 = {
        32'h3F80_0000, 32'hBF80_0000, 32'h402D_F854, 32'h3F80_0000,
        32'h0080_0000, 32'h3380_0000, 32'h3F80_0000, 32'h4040_0000
    };

    // Clamp the exponent into the normal range so no NaN/Inf/denormal escapes.
    function automatic logic [31:0] sanitize(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (v[30:23] < FP32_EXP_MIN) begin
            r[30:23] = FP32_EXP_MIN;
        end else if (v[30:23] > FP32_EXP_MAX) begin
            r[30:23] = FP32_EXP_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous seed reload and gated stepping.
// A zero seed would lock up the register, so it is replaced by 1.
module lfsr_galois #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] MASK = '1,
    parameter logic [WIDTH-1:0] SEED = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED_EFF;
        end else if (load) begin
            q <= SEED_EFF;
        end else if (step) begin
            q <= (q >> 1) ^ (q[0] ? MASK : '0);
        end
    end

endmodule

// File: rtl/fp32_add_stim.sv
// Stimulus sequencer for the fp32 adder: directed table, then LFSR-driven random
// normal-range pairs, optional bubbles, a drain interval and a one-cycle over pulse.
//
// state       | meaning
// ST_IDLE     | waiting for start after reset
// ST_DIRECTED | issuing directed table entries 1..7 (entry 0 goes out on the start edge)
// ST_RANDOM   | issuing NUM_RANDOM sanitised LFSR operand pairs
// ST_DRAIN    | val held low while the adder pipeline empties
// ST_DONE     | run complete, vec_cnt holds, start re-arms
module fp32_add_stim
    import fp32_tb_pkg::*;
#(
    parameter int unsigned NUM_RANDOM   = 1000,
    parameter logic [31:0] SEED         = 32'hACE1_2468,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        gap_en,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic        val,
    output logic        over,
    output logic        busy,
    output logic [31:0] vec_cnt
);

    localparam logic [31:0] RND_LAST   = (NUM_RANDOM == 0) ? 32'd0 : 32'(NUM_RANDOM - 1);
    localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  dir_idx, dir_idx_nx;
    logic [31:0] rnd_cnt, rnd_cnt_nx;
    logic [31:0] drain_cnt, drain_cnt_nx;
    logic [31:0] x1_nx, x2_nx;
    logic        over_nx, issue, issue_rnd;
    logic [31:0] lfsr_a, lfsr_b;
    logic [15:0] lfsr_bub;
    logic        accept, run_phase, bubble;

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign run_phase = (state == ST_DIRECTED) || (state == ST_RANDOM);
    assign bubble    = run_phase && gap_en && lfsr_bub[0];

    lfsr_galois #(.WIDTH(32), .MASK(OPND_MASK), .SEED(SEED)) u_lfsr_x1 (
        .clk(clk), .rst(rst), .load(accept), .step(issue_rnd), .q(lfsr_a)
    );

    lfsr_galois #(.WIDTH(32), .MASK(OPND_MASK), .SEED(SEED ^ X2_SEED_XOR)) u_lfsr_x2 (
        .clk(clk), .rst(rst), .load(accept), .step(issue_rnd), .q(lfsr_b)
    );

    lfsr_galois #(.WIDTH(16), .MASK(BUBBLE_MASK), .SEED(BUBBLE_SEED)) u_lfsr_bub (
        .clk(clk), .rst(rst), .load(accept), .step(run_phase), .q(lfsr_bub)
    );

    // Each cycle decides what the output registers show next; the start edge
    // itself issues directed entry 0 so val rises the cycle after start.
    always_comb begin
        state_nx     = state;
        dir_idx_nx   = dir_idx;
        rnd_cnt_nx   = rnd_cnt;
        drain_cnt_nx = drain_cnt;
        x1_nx        = '0;
        x2_nx        = '0;
        over_nx      = 1'b0;
        issue        = 1'b0;
        issue_rnd    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    issue      = 1'b1;
                    x1_nx      = DIR_X1[0];
                    x2_nx      = DIR_X2[0];
                    dir_idx_nx = 3'd1;
                    rnd_cnt_nx = '0;
                    state_nx   = ST_DIRECTED;
                end
            end
            ST_DIRECTED: begin
                if (!bubble) begin
                    issue      = 1'b1;
                    x1_nx      = DIR_X1[dir_idx];
                    x2_nx      = DIR_X2[dir_idx];
                    dir_idx_nx = dir_idx + 3'd1;
                    if (dir_idx == 3'd7) begin
                        if (NUM_RANDOM == 0) begin
                            state_nx     = ST_DRAIN;
                            drain_cnt_nx = DRAIN_LOAD;
                        end else begin
                            state_nx = ST_RANDOM;
                        end
                    end
                end
            end
            ST_RANDOM: begin
                if (!bubble) begin
                    issue      = 1'b1;
                    issue_rnd  = 1'b1;
                    x1_nx      = sanitize(lfsr_a);
                    x2_nx      = sanitize(lfsr_b);
                    rnd_cnt_nx = rnd_cnt + 32'd1;
                    if (rnd_cnt == RND_LAST) begin
                        state_nx     = ST_DRAIN;
                        drain_cnt_nx = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    over_nx  = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    drain_cnt_nx = drain_cnt - 32'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            dir_idx   <= '0;
            rnd_cnt   <= '0;
            drain_cnt <= '0;
            x1        <= '0;
            x2        <= '0;
            val       <= 1'b0;
            over      <= 1'b0;
            busy      <= 1'b0;
            vec_cnt   <= '0;
        end else begin
            state     <= state_nx;
            dir_idx   <= dir_idx_nx;
            rnd_cnt   <= rnd_cnt_nx;
            drain_cnt <= drain_cnt_nx;
            x1        <= x1_nx;
            x2        <= x2_nx;
            val       <= issue;
            over      <= over_nx;
            busy      <= (state_nx == ST_DIRECTED) || (state_nx == ST_RANDOM) ||
                         (state_nx == ST_DRAIN);
            if (accept) begin
                vec_cnt <= 32'd1;
            end else if (issue && vec_cnt != '1) begin
                vec_cnt <= vec_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_add_stim.sv
// Directed bench for fp32_add_stim: one instance with 1000 random vectors, one with none.
// Expected operand streams come from the hand-copied table and a local LFSR model.
module tb_fp32_add_stim;

    localparam int          NRND  = 1000;
    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam int          DRAIN = 8;
    localparam int          NTOT  = 8 + NRND;

    logic        clk, rst, start, start_n0, gap_en;
    logic [31:0] x1, x2, vec_cnt, x1_n0, x2_n0, vec_cnt_n0;
    logic        val, over, busy, val_n0, over_n0, busy_n0;

    int errs = 0;
    int checks = 0;

    logic [31:0] exp_x1[$], exp_x2[$], got_x1[$], got_x2[$];
    int last_val_cyc, over_cyc, over_pulses, idle_nonzero, cnt_bad, busy_bad, seen;
    logic timed_out;

    fp32_add_stim #(.NUM_RANDOM(NRND), .SEED(SEED), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .gap_en(gap_en),
        .x1(x1), .x2(x2), .val(val), .over(over), .busy(busy), .vec_cnt(vec_cnt)
    );

    fp32_add_stim #(.NUM_RANDOM(0), .SEED(SEED), .DRAIN_CYCLES(DRAIN)) dut_n0 (
        .clk(clk), .rst(rst), .start(start_n0), .gap_en(gap_en),
        .x1(x1_n0), .x2(x2_n0), .val(val_n0), .over(over_n0), .busy(busy_n0),
        .vec_cnt(vec_cnt_n0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] clamp_exp(input logic [31:0] v);
        logic [7:0] e;
        e = v[30:23];
        if (e == 8'h00) e = 8'h01;
        if (e == 8'hFF) e = 8'hFE;
        return {v[31], e, v[22:0]};
    endfunction

    task automatic build_expected();
        logic [31:0] d1 [8];
        logic [31:0] d2 [8];
        logic [31:0] s1, s2;
        d1 = '{32'h3F800000, 32'h3F800000, 32'h40490FDB, 32'h7F7FFFFF,
               32'h00800000, 32'h3F800000, 32'h4B7FFFFF, 32'hC0A00000};
        d2 = '{32'h3F800000, 32'hBF800000, 32'h402DF854, 32'h3F800000,
               32'h00800000, 32'h33800000, 32'h3F800000, 32'h40400000};
        for (int i = 0; i < 8; i++) begin
            exp_x1.push_back(d1[i]);
            exp_x2.push_back(d2[i]);
        end
        s1 = SEED;
        s2 = SEED ^ 32'h5A5A_5A5A;
        for (int i = 0; i < NRND; i++) begin
            exp_x1.push_back(clamp_exp(s1));
            exp_x2.push_back(clamp_exp(s2));
            s1 = lfsr_next(s1);
            s2 = lfsr_next(s2);
        end
    endtask

    // Runs one start..over sequence on the main instance, logging every cycle.
    task automatic capture(input logic gap, input int inject_at);
        int cyc;
        logic done;
        got_x1.delete();
        got_x2.delete();
        last_val_cyc = -1; over_cyc = -1; over_pulses = 0;
        idle_nonzero = 0; cnt_bad = 0; busy_bad = 0; seen = 0;
        gap_en = gap;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 6000) begin
            start = (cyc == inject_at);
            if (val) begin
                got_x1.push_back(x1);
                got_x2.push_back(x2);
                last_val_cyc = cyc;
                seen++;
            end else if (x1 != '0 || x2 != '0) begin
                idle_nonzero++;
            end
            if (vec_cnt != 32'(seen)) cnt_bad++;
            if ((over_cyc < 0 && !over && !busy) || (over && busy)) busy_bad++;
            if (over) begin
                over_pulses++;
                if (over_cyc < 0) over_cyc = cyc;
            end
            if (over_cyc >= 0 && cyc >= over_cyc + 3) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        timed_out = !done;
    endtask

    task automatic check_run(input string tag, input logic gap);
        int seq_bad, exp_bad, nmin;
        check({tag, ".timeout"}, 32'(timed_out), 32'd0);
        check({tag, ".nval"}, 32'(got_x1.size()), 32'(NTOT));
        nmin = (got_x1.size() < NTOT) ? got_x1.size() : NTOT;
        seq_bad = 0;
        exp_bad = 0;
        for (int i = 0; i < nmin; i++) begin
            if (got_x1[i] !== exp_x1[i] || got_x2[i] !== exp_x2[i]) seq_bad++;
            if (got_x1[i][30:23] == 8'h00 || got_x1[i][30:23] == 8'hFF ||
                got_x2[i][30:23] == 8'h00 || got_x2[i][30:23] == 8'hFF) exp_bad++;
        end
        check({tag, ".seq_mismatches"}, 32'(seq_bad), 32'd0);
        check({tag, ".bad_exponents"}, 32'(exp_bad), 32'd0);
        if (nmin > 8) begin
            check({tag, ".first_rnd_x1"}, got_x1[8], exp_x1[8]);
            check({tag, ".first_rnd_x2"}, got_x2[8], exp_x2[8]);
        end
        check({tag, ".idle_nonzero"}, 32'(idle_nonzero), 32'd0);
        check({tag, ".vec_cnt_track"}, 32'(cnt_bad), 32'd0);
        check({tag, ".busy_track"}, 32'(busy_bad), 32'd0);
        check({tag, ".over_pulses"}, 32'(over_pulses), 32'd1);
        check({tag, ".over_delay"}, 32'(over_cyc - last_val_cyc), 32'(DRAIN));
        check({tag, ".vec_cnt_final"}, vec_cnt, 32'(NTOT));
        if (gap) begin
            check({tag, ".bubbles_seen"}, 32'(last_val_cyc + 1 > NTOT), 32'd1);
        end else begin
            check({tag, ".contiguous"}, 32'(last_val_cyc + 1), 32'(NTOT));
        end
    endtask

    // Zero-random instance: 8 directed vectors then drain.
    task automatic run_n0(input string tag);
        int nv, lastv, overc, pulses;
        logic [31:0] f1, f2, l1, l2;
        nv = 0; lastv = -1; overc = -1; pulses = 0;
        f1 = '0; f2 = '0; l1 = '0; l2 = '0;
        gap_en = 1'b0;
        @(negedge clk); start_n0 = 1'b1;
        @(negedge clk); start_n0 = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy_n0), 32'd1);
        check({tag, ".vec_cnt_restart"}, vec_cnt_n0, 32'd1);
        for (int c = 0; c < 40; c++) begin
            if (val_n0) begin
                if (nv == 0) begin f1 = x1_n0; f2 = x2_n0; end
                l1 = x1_n0; l2 = x2_n0;
                nv++;
                lastv = c;
            end
            if (over_n0) begin
                pulses++;
                if (overc < 0) overc = c;
            end
            @(negedge clk);
        end
        check({tag, ".nval"}, 32'(nv), 32'd8);
        check({tag, ".contiguous"}, 32'(lastv + 1), 32'd8);
        check({tag, ".first_x1"}, f1, 32'h3F800000);
        check({tag, ".first_x2"}, f2, 32'h3F800000);
        check({tag, ".last_x1"}, l1, 32'hC0A00000);
        check({tag, ".last_x2"}, l2, 32'h40400000);
        check({tag, ".over_delay"}, 32'(overc - lastv), 32'(DRAIN));
        check({tag, ".over_pulses"}, 32'(pulses), 32'd1);
        check({tag, ".vec_cnt"}, vec_cnt_n0, 32'd8);
        check({tag, ".busy_done"}, 32'(busy_n0), 32'd0);
    endtask

    initial begin
        int ov;
        rst = 1'b0; start = 1'b0; start_n0 = 1'b0; gap_en = 1'b0;
        build_expected();
        repeat (3) @(negedge clk);
        check("reset.x1", x1, 32'd0);
        check("reset.x2", x2, 32'd0);
        check("reset.flags", {29'd0, val, over, busy}, 32'd0);
        check("reset.vec_cnt", vec_cnt, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_n0("n0_run1");
        run_n0("n0_run2");

        capture(1'b0, -1);
        check_run("gap0_a", 1'b0);
        capture(1'b0, -1);
        check_run("gap0_b", 1'b0);
        capture(1'b1, -1);
        check_run("gap1", 1'b1);
        capture(1'b0, 100);
        check_run("start_in_random", 1'b0);

        gap_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        check("midrun.busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrun.x1", x1, 32'd0);
        check("midrun.x2", x2, 32'd0);
        check("midrun.flags", {29'd0, val, over, busy}, 32'd0);
        check("midrun.vec_cnt", vec_cnt, 32'd0);
        ov = 0;
        repeat (5) begin
            @(negedge clk);
            if (over) ov++;
        end
        #2 rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (over || busy) ov++;
        end
        check("midrun.no_over", 32'(ov), 32'd0);
        capture(1'b0, -1);
        check_run("replay", 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
